// File: rtl/pipe_register_pkg.sv
// Shared defaults for the pipe_register elastic pipeline.
// Also provides the occupancy-counter width helper used by surrounding logic and benches.
package pipe_register_pkg;

  localparam int PIPE_WIDTH_DEF  = 4;
  localparam int PIPE_STAGES_DEF = 2;
  localparam int PIPE_OCC_W_DEF  = $clog2(PIPE_STAGES_DEF + 1);

  // Bits needed to count 0..stages words held in the pipeline.
  function automatic int pipe_occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One valid/data slot of the elastic pipeline; it takes a new word whenever
// it is empty or its downstream neighbour is consuming.
module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_dn_ready,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  // An empty slot accepts even while downstream stalls, collapsing bubbles.
  assign o_rdy = i_dn_ready | ~r_vld;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  // NOTE: non-blocking assignments keep every stage sampling its neighbour's
  // pre-edge value, which is what makes the chain shift instead of ripple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      if (i_flush) begin
        r_vld <= 1'b0;
      end else if (o_rdy) begin
        r_vld <= i_up_valid;
      end
      // Data only moves with a real word, so bubbles leave the register quiet.
      if (!i_flush && o_rdy && i_up_valid) begin
        r_dat <= i_up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Multi-stage valid/ready pipeline register with full backpressure and bubble collapsing.
// Optional synchronous flush port enabled by defining PIPE_REGISTER_FLUSH_EN.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int WIDTH  = PIPE_WIDTH_DEF,
  parameter int STAGES = PIPE_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_REGISTER_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             w_flush;
  logic [STAGES:0]  w_vld;
  logic [WIDTH-1:0] w_dat [STAGES+1];

`ifdef PIPE_REGISTER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Index 0 is the upstream port; index g+1 is the output of stage g.
  assign w_vld[0] = in_valid;
  assign w_dat[0] = in_data;

  // Ready lives in per-stage scopes so the backward chain is not one
  // self-referencing vector.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic w_rdy;
    logic w_dn_rdy;

    if (g == STAGES - 1) begin : g_last
      assign w_dn_rdy = out_ready;
    end else begin : g_mid
      assign w_dn_rdy = g_stage[g+1].w_rdy;
    end

    pipe_register_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (w_flush),
      .i_up_valid (w_vld[g]),
      .i_up_data  (w_dat[g]),
      .i_dn_ready (w_dn_rdy),
      .o_rdy      (w_rdy),
      .o_vld      (w_vld[g+1]),
      .o_dat      (w_dat[g+1])
    );
  end

  assign in_ready  = g_stage[0].w_rdy & ~w_flush;
  assign out_valid = w_vld[STAGES];
  assign out_data  = w_dat[STAGES];

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register (WIDTH=8, STAGES=3): a timestamped word
// queue predicts readiness, output validity/latency and FIFO order.
module tb_pipe_register;
  import pipe_register_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int OCC_W  = pipe_occ_width(STAGES);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } word_t;
  word_t sb_q[$];

  pipe_register #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PIPE_REGISTER_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the pipeline is a FIFO of capacity STAGES; the oldest
  // word becomes visible STAGES-1 edges after it was accepted.
  always @(negedge clk) begin
    logic fl, exp_rdy, exp_ov;
`ifdef PIPE_REGISTER_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    if (!rst_n) begin
      sb_q.delete();
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_data", {24'd0, out_data}, 32'd0);
    end else begin
      exp_rdy = !fl && (sb_q.size() < STAGES || out_ready);
      exp_ov  = sb_q.size() > 0 && (cyc - sb_q[0].t >= STAGES - 1);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov) check("out_data", {24'd0, out_data}, {24'd0, sb_q[0].d});
      if (exp_ov && out_ready) void'(sb_q.pop_front());
      if (fl) sb_q.delete();
      else if (in_valid && exp_rdy) sb_q.push_back('{d: in_data, t: cyc + 1});
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    tick(n);
  endtask

  // Present a word and hold it until the DUT takes it (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: word %0h not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    idle(2);

    // Asynchronous reset seen without waiting for an edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_data", {24'd0, out_data}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(8'(i));
    idle(6);

    // Backpressure: fill, stall with A3 pending, then release.
    out_ready = 1'b0;
    send(8'hA0);
    send(8'hA1);
    send(8'hA2);
    in_valid = 1'b1;
    in_data  = 8'hA3;
    tick(4);
    out_ready = 1'b1;
    send(8'hA3);
    idle(6);

    // Bubble collapse under a stalled output.
    out_ready = 1'b0;
    send(8'h11);
    idle(1);
    send(8'h22);
    idle(1);
    send(8'h33);
    idle(3);
    out_ready = 1'b1;
    idle(6);

    // Reset while two words are in flight.
    out_ready = 1'b0;
    send(8'h77);
    send(8'h78);
    idle(3);
    #1 rst_n = 1'b0;
    #1;
    check("midop_rst_out_valid", {31'd0, out_valid}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h5A);
    idle(6);

`ifdef PIPE_REGISTER_FLUSH_EN
    out_ready = 1'b0;
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    tick(1);
    flush = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send(8'hD1);
    send(8'hD2);
    send(8'hD3);
    idle(6);
`endif

    // Randomised traffic with irregular stalls.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef PIPE_REGISTER_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      tick(1);
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(STAGES + OCC_W + 4);
    check("drained_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
